// File: rtl/riscv_pkg.sv
// Shared types and encodings for the RV32 pipeline hazard controller.
package riscv_pkg;

  typedef enum logic {
    IDLE,
    MEM_WAIT
  } state_t;

  localparam logic [1:0] FWD_RF      = 2'b00;
  localparam logic [1:0] FWD_W       = 2'b01;
  localparam logic [1:0] FWD_M       = 2'b10;
  localparam logic [1:0] RESULT_LOAD = 2'b01;

  // M has priority over W because it holds the younger result; x0 is never a producer.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rd_m,
                                         input logic       wr_m,
                                         input logic [4:0] rd_w,
                                         input logic       wr_w);
    logic [1:0] sel;
    sel = FWD_RF;
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = FWD_M;
    end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_fwd.sv
// Combinational E-stage forwarding selects and load-use hazard detection.
module hazard_fwd
  import riscv_pkg::*;
(
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic [1:0] ResultSrcE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       lw_stall
);

  always_comb begin
    ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
    lw_stall  = (ResultSrcE == RESULT_LOAD) && (RdE != 5'd0) &&
                ((RdE == Rs1D) || (RdE == Rs2D));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush/forward controller with a data-memory wait FSM and timeout.
module pipe_hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_W   = 8,
  parameter int unsigned MEM_TIMEOUT = 200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic [1:0]  ResultSrcE,
  input  logic        PCSrcE,
  input  logic        MemAccessM,
  input  logic        dmem_ready,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        dmem_req,
  output logic        mem_err,
  output logic [31:0] stall_cycles
);

  localparam logic [TIMEOUT_W-1:0] TimeoutVal = TIMEOUT_W'(MEM_TIMEOUT);

  state_t               state_q, state_d;
  logic [TIMEOUT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]          stall_cnt_q;

  logic [1:0] fwd_a, fwd_b;
  logic       lw_stall;
  logic       mem_stall;
  logic       timeout;
  logic       req;

  hazard_fwd u_hazard_fwd (
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .Rs1E       (Rs1E),
    .Rs2E       (Rs2E),
    .RdE        (RdE),
    .RdM        (RdM),
    .RdW        (RdW),
    .RegWriteM  (RegWriteM),
    .RegWriteW  (RegWriteW),
    .ResultSrcE (ResultSrcE),
    .ForwardAE  (fwd_a),
    .ForwardBE  (fwd_b),
    .lw_stall   (lw_stall)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_stall  = 1'b0;
    timeout    = 1'b0;
    req        = 1'b0;
    unique case (state_q)
      IDLE: begin
        req = MemAccessM;
        if (MemAccessM && !dmem_ready) begin
          mem_stall  = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = TIMEOUT_W'(1);
        end
      end
      MEM_WAIT: begin
        req = 1'b1;
        if (dmem_ready) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q < TimeoutVal) begin
          mem_stall  = 1'b1;
          wait_cnt_d = wait_cnt_q + TIMEOUT_W'(1);
        end else begin
          // Abandon the access: release the pipe but bubble W so nothing retires.
          timeout    = 1'b1;
          state_d    = IDLE;
          wait_cnt_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  // While reset is held every control output is forced inactive, regardless of inputs.
  always_comb begin
    StallF    = reset & (mem_stall | lw_stall);
    StallD    = reset & (mem_stall | lw_stall);
    StallE    = reset & mem_stall;
    StallM    = reset & mem_stall;
    FlushD    = reset & ~mem_stall & PCSrcE;
    FlushE    = reset & ~mem_stall & (lw_stall | PCSrcE);
    FlushW    = reset & (mem_stall | timeout);
    dmem_req  = reset & req;
    mem_err   = reset & timeout;
    ForwardAE = reset ? fwd_a : FWD_RF;
    ForwardBE = reset ? fwd_b : FWD_RF;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (StallF) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then randomized traffic.
module tb_pipe_hazard_ctrl;

  localparam int unsigned TMO = 4;

  typedef struct packed {
    logic [3:0]  stalls;   // F,D,E,M
    logic [2:0]  flushes;  // D,E,W
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        req;
    logic        err;
    logic [31:0] sc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        RegWriteM, RegWriteW;
  logic [1:0]  ResultSrcE;
  logic        PCSrcE, MemAccessM, dmem_ready;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        dmem_req, mem_err;
  logic [31:0] stall_cycles;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  exp_t exp_q[$];

  // Reference state: "waiting" means a memory access is outstanding, cnt is cycles waited.
  bit          m_waiting = 1'b0;
  int          m_cnt     = 0;
  logic [31:0] m_sc      = 32'd0;

  pipe_hazard_ctrl #(.TIMEOUT_W(8), .MEM_TIMEOUT(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .Rs1D         (Rs1D),
    .Rs2D         (Rs2D),
    .Rs1E         (Rs1E),
    .Rs2E         (Rs2E),
    .RdE          (RdE),
    .RdM          (RdM),
    .RdW          (RdW),
    .RegWriteM    (RegWriteM),
    .RegWriteW    (RegWriteW),
    .ResultSrcE   (ResultSrcE),
    .PCSrcE       (PCSrcE),
    .MemAccessM   (MemAccessM),
    .dmem_ready   (dmem_ready),
    .StallF       (StallF),
    .StallD       (StallD),
    .StallE       (StallE),
    .StallM       (StallM),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .FlushW       (FlushW),
    .ForwardAE    (ForwardAE),
    .ForwardBE    (ForwardBE),
    .dmem_req     (dmem_req),
    .mem_err      (mem_err),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] fwd_model(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clear_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0;
    PCSrcE = 0; MemAccessM = 0; dmem_ready = 0;
  endtask

  // Predict this cycle's outputs from the current inputs, queue them, advance to next cycle.
  task automatic tick();
    exp_t e;
    bit   lw, stall_mem, tmo;
    e = '0;
    if (!reset) begin
      m_waiting = 1'b0;
      m_cnt     = 0;
      m_sc      = 32'd0;
    end else begin
      lw = (ResultSrcE == 2'b01) && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
      if (!m_waiting) begin
        stall_mem = MemAccessM && !dmem_ready;
        tmo       = 1'b0;
      end else begin
        stall_mem = !dmem_ready && (m_cnt < TMO);
        tmo       = !dmem_ready && (m_cnt >= TMO);
      end
      e.fwd_a = fwd_model(Rs1E);
      e.fwd_b = fwd_model(Rs2E);
      e.req   = m_waiting ? 1'b1 : MemAccessM;
      e.err   = tmo;
      e.sc    = m_sc;
      if (stall_mem) begin
        e.stalls  = 4'b1111;
        e.flushes = 3'b001;
      end else begin
        e.stalls  = {lw, lw, 2'b00};
        e.flushes = {PCSrcE, lw | PCSrcE, tmo};
      end
      if (e.stalls[3]) m_sc = m_sc + 32'd1;
      if (!m_waiting) begin
        if (stall_mem) begin m_waiting = 1'b1; m_cnt = 1; end
      end else if (dmem_ready || tmo) begin
        m_waiting = 1'b0; m_cnt = 0;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Monitor: outputs are settled mid-cycle, compare against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stalls", 32'({StallF, StallD, StallE, StallM}), 32'(e.stalls));
        chk("flushes", 32'({FlushD, FlushE, FlushW}), 32'(e.flushes));
        chk("forward", 32'({ForwardAE, ForwardBE}), 32'({e.fwd_a, e.fwd_b}));
        chk("dmem_req", 32'(dmem_req), 32'(e.req));
        chk("mem_err", 32'(mem_err), 32'(e.err));
        chk("stall_cycles", stall_cycles, e.sc);
        cyc++;
      end
    end
  end

  initial begin
    int drain;
    reset = 1'b0;
    clear_inputs();
    @(posedge clk);
    #1;
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Forwarding priority and x0
    RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 5;
    tick();
    RegWriteM = 0;
    tick();
    RegWriteM = 1; RdM = 0; RdW = 0; Rs1E = 0; Rs2E = 0;
    tick();
    clear_inputs();

    // Load-use, plus x0 destination must not stall
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    tick();
    clear_inputs();
    ResultSrcE = 2'b01; RdE = 0; Rs1D = 0;
    tick();
    clear_inputs();
    tick();

    // Taken branch
    PCSrcE = 1;
    tick();
    clear_inputs();

    // Memory wait: three not-ready cycles then ready
    MemAccessM = 1;
    repeat (3) tick();
    dmem_ready = 1;
    tick();
    clear_inputs();
    tick();

    // Ready in IDLE without an access is ignored
    dmem_ready = 1;
    tick();
    clear_inputs();

    // Timeout
    MemAccessM = 1;
    repeat (TMO + 1) tick();
    clear_inputs();
    tick();

    // Branch pending across a memory wait
    MemAccessM = 1; PCSrcE = 1;
    repeat (2) tick();
    dmem_ready = 1;
    tick();
    clear_inputs();
    tick();

    // Reset mid-wait
    MemAccessM = 1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    MemAccessM = 0;
    tick();

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      reset      = ($urandom_range(0, 99) != 0);
      Rs1D       = 5'($urandom_range(0, 3));
      Rs2D       = 5'($urandom_range(0, 3));
      Rs1E       = 5'($urandom_range(0, 3));
      Rs2E       = 5'($urandom_range(0, 3));
      RdE        = 5'($urandom_range(0, 3));
      RdM        = 5'($urandom_range(0, 3));
      RdW        = 5'($urandom_range(0, 3));
      RegWriteM  = 1'($urandom_range(0, 1));
      RegWriteW  = 1'($urandom_range(0, 1));
      ResultSrcE = 2'($urandom_range(0, 3));
      PCSrcE     = ($urandom_range(0, 4) == 0);
      MemAccessM = ($urandom_range(0, 3) == 0);
      dmem_ready = 1'($urandom_range(0, 1));
      tick();
    end
    reset = 1'b1;
    clear_inputs();

    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush/forward controller for the 5-stage RV32 pipeline (F/D/E/M/W).
- Detects RAW hazards and produces E-stage forwarding selects.
- Inserts load-use bubbles and redirects on taken branch/jump.
- Runs a small FSM that freezes the pipeline while a data-memory access in M waits on dmem_ready; a timeout abandons hung accesses.

Parameters:
- TIMEOUT_W, 8, width of the memory-wait counter.
- MEM_TIMEOUT, 200, wait cycles before an access is abandoned; must be < 2^TIMEOUT_W.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset
- Rs1D, Rs2D  in  5 each  source registers in D
- Rs1E, Rs2E, RdE  in  5 each  sources/destination in E
- RdM, RdW  in  5 each  destinations in M/W
- RegWriteM, RegWriteW  in  1 each  register-write enables in M/W
- ResultSrcE  in  2  result select in E; 2'b01 = load
- PCSrcE  in  1  taken branch/jump resolved in E
- MemAccessM  in  1  load or store present in M
- dmem_ready  in  1  data memory completes access this cycle
- StallF, StallD, StallE, StallM  out  1 each  hold stage registers
- FlushD, FlushE, FlushW  out  1 each  load bubble into stage register
- ForwardAE, ForwardBE  out  2 each  E operand select: 00 regfile, 01 W result, 10 M ALU result
- dmem_req  out  1  memory request qualifier
- mem_err  out  1  one-cycle pulse on timeout
- stall_cycles  out  32  count of cycles with StallF=1

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, wait_cnt=0, mem_err=0, stall_cycles=0.
  - All stall/flush/dmem_req outputs forced to 0.
  - ForwardAE/BE=00.
- Forwarding (combinational), same rule for B using Rs2E:
  - ForwardAE=10 if RegWriteM and RdM!=0 and RdM==Rs1E.
  - Else 01 if RegWriteW and RdW!=0 and RdW==Rs1E.
  - Else 00.
  - M has priority over W.
- lwStall = (ResultSrcE==01) and RdE!=0 and (RdE==Rs1D or RdE==Rs2D).
- memStall:
  - IDLE: MemAccessM and !dmem_ready.
  - MEM_WAIT: !dmem_ready and wait_cnt<MEM_TIMEOUT.
- dmem_req = MemAccessM in IDLE; 1 in MEM_WAIT.
- Output equations:
  - Memory stall: StallF=StallD=StallE=StallM=1, FlushW=1 (bubble into W).
  - Memory stall: FlushD=FlushE=0; a pending PCSrcE is held in the stalled E register and acts on the release cycle.
  - Otherwise: StallF=StallD=lwStall, StallE=StallM=0, FlushW=0, FlushD=PCSrcE, FlushE=lwStall or PCSrcE.
- FSM (registered; outputs combinational from state + inputs):
  - IDLE -> MEM_WAIT when MemAccessM and !dmem_ready; wait_cnt<=1.
  - MEM_WAIT, dmem_ready=1 -> IDLE. Stalls drop in the same cycle, so M->W captures on that edge. wait_cnt<=0.
  - MEM_WAIT, !dmem_ready and wait_cnt<MEM_TIMEOUT -> stay; wait_cnt++.
  - MEM_WAIT, !dmem_ready and wait_cnt==MEM_TIMEOUT -> IDLE, mem_err=1 for one cycle, stalls released, FlushW=1 that cycle. Access is discarded.
- dmem_ready in IDLE without MemAccessM is ignored.
- stall_cycles increments every cycle StallF=1 and wraps at 2^32-1 -> 0.
- Reset asserted mid-MEM_WAIT aborts immediately to IDLE; no mem_err pulse.
- x0 is never forwarded and never causes lwStall.

Decomposition:
- Package riscv_pkg holds:
  - state enum {IDLE, MEM_WAIT}
  - forward encodings FWD_RF=00, FWD_W=01, FWD_M=10
  - RESULT_LOAD=2'b01
- Sub-module hazard_fwd: purely combinational forwarding + lwStall logic, one instance.
- The FSM, timeout counter and perf counter stay in pipe_hazard_ctrl.

Test Plan:
- Forwarding: RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10. Then RegWriteM=0 -> 01. Then RdM=RdW=0, Rs1E=0 -> 00.
- Load-use: ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=1, FlushE=1 for exactly one cycle; stall_cycles +1.
- Branch: PCSrcE=1, no other hazard -> FlushD=FlushE=1, StallF=0.
- Memory wait: MemAccessM=1, dmem_ready low 3 cycles then high.
  - Expect StallF/D/E/M=1 and FlushW=1 for 3 cycles.
  - Release on the 4th cycle; dmem_req high for all 4 cycles; state back to IDLE.
- Timeout (MEM_TIMEOUT=4): dmem_ready held 0 -> mem_err pulses once at wait_cnt==4, stalls drop, FSM in IDLE.
- Branch pending during memory wait: PCSrcE=1 during a 2-cycle wait -> FlushD/FlushE=0 while stalled, then =1 on the release cycle.
- Reset mid-wait: async reset low -> all outputs 0 immediately, no mem_err, stall_cycles=0.
